// File: rtl/instr_fe_pkg.sv
// Shared definitions for the instruction fetch stage: encodings, NOP word,
// PC increment and the fetch-FSM state type.
package instr_fe_pkg;

  localparam logic [31:0] FE_NOP    = 32'h0000_0013;
  localparam logic [31:0] FE_PC_INC = 32'd4;

  typedef enum logic [1:0] {
    FE_REQ  = 2'd0,
    FE_WAIT = 2'd1,
    FE_HOLD = 2'd2
  } fe_state_t;

  // Redirect targets are word aligned; the low two bits are dropped.
  function automatic logic [31:0] fe_align(input logic [31:0] addr);
    fe_align = {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fe.sv
// Instruction fetch stage: single-outstanding strobe/ack fetch towards
// instruction memory, one-entry hold buffer for stalls, redirect with squash.
module instr_fe
  import instr_fe_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = FE_NOP
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] o_iaddr,
  output logic        o_stb,
  input  logic        i_ack,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_clk_en,
  input  logic        i_stall,
  input  logic        i_change_pc,
  input  logic [31:0] i_new_pc
);

  fe_state_t   state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic        discard_r, discard_s;
  logic [31:0] instr_r, instr_s;
  logic [31:0] pc_out_r, pc_out_s;
  logic        clk_en_r, clk_en_s;
  logic [31:0] buf_r, buf_s;
  logic        stb_s;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= FE_REQ;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a redirect always returns to REQ unless a request is
  // still outstanding without its ack.
  always_comb begin
    state_s = state_r;
    case (state_r)
      FE_REQ: begin
        if (i_change_pc) state_s = FE_REQ;
        else             state_s = FE_WAIT;
      end
      FE_WAIT: begin
        if (!i_ack)                                 state_s = FE_WAIT;
        else if (i_change_pc || discard_r || !i_stall) state_s = FE_REQ;
        else                                        state_s = FE_HOLD;
      end
      FE_HOLD: begin
        if (i_change_pc || !i_stall) state_s = FE_REQ;
        else                         state_s = FE_HOLD;
      end
      default: state_s = FE_REQ;
    endcase
  end

  // Output logic: the strobe is withdrawn in the cycle a redirect arrives
  always_comb begin
    if ((state_r == FE_REQ) && !i_change_pc && rstn) stb_s = 1'b1;
    else                                             stb_s = 1'b0;
  end

  // Datapath next values: PC, squash flag, hold buffer and decode outputs
  always_comb begin
    pc_s      = pc_r;
    discard_s = discard_r;
    instr_s   = instr_r;
    pc_out_s  = pc_out_r;
    clk_en_s  = clk_en_r;
    buf_s     = buf_r;
    if (i_change_pc) begin
      pc_s     = fe_align(i_new_pc);
      clk_en_s = 1'b0;
      buf_s    = NOP_INSTR;
      if (state_r == FE_WAIT) discard_s = !i_ack;
      else                    discard_s = discard_r;
    end else begin
      if (i_stall) clk_en_s = clk_en_r;
      else         clk_en_s = 1'b0;
      case (state_r)
        FE_WAIT: begin
          if (!i_ack) begin
            discard_s = discard_r;
          end else if (discard_r) begin
            discard_s = 1'b0;
          end else if (!i_stall) begin
            instr_s  = i_rdata;
            pc_out_s = pc_r;
            clk_en_s = 1'b1;
            pc_s     = pc_r + FE_PC_INC;
          end else begin
            buf_s = i_rdata;
          end
        end
        FE_HOLD: begin
          if (!i_stall) begin
            instr_s  = buf_r;
            pc_out_s = pc_r;
            clk_en_s = 1'b1;
            pc_s     = pc_r + FE_PC_INC;
          end else begin
            buf_s = buf_r;
          end
        end
        FE_REQ:  buf_s = buf_r;
        default: buf_s = buf_r;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_r      <= PC_RESET;
      discard_r <= 1'b0;
      instr_r   <= NOP_INSTR;
      pc_out_r  <= 32'd0;
      clk_en_r  <= 1'b0;
      buf_r     <= NOP_INSTR;
    end else begin
      pc_r      <= pc_s;
      discard_r <= discard_s;
      instr_r   <= instr_s;
      pc_out_r  <= pc_out_s;
      clk_en_r  <= clk_en_s;
      buf_r     <= buf_s;
    end
  end

  assign o_iaddr  = pc_r;
  assign o_stb    = stb_s;
  assign o_instr  = instr_r;
  assign o_pc     = pc_out_r;
  assign o_clk_en = clk_en_r;

endmodule
